// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: stall patterns, FSM states,
// perf-counter select codes and the stall priority encoder.
package pipe_ctrl_pkg;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Bit k holds stage k (0=PC ... 5=WB); WB is never held.
    localparam logic [5:0] StallMem  = {NoStop, Stop, Stop, Stop, Stop, Stop};
    localparam logic [5:0] StallEx   = {NoStop, NoStop, Stop, Stop, Stop, Stop};
    localparam logic [5:0] StallId   = {NoStop, NoStop, NoStop, Stop, Stop, Stop};
    localparam logic [5:0] StallIf   = {NoStop, NoStop, NoStop, NoStop, Stop, Stop};
    localparam logic [5:0] StallNone = {6{NoStop}};

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StWaitMem = 2'd1,
        StFlush   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PerfIf  = 2'd0,
        PerfId  = 2'd1,
        PerfEx  = 2'd2,
        PerfMem = 2'd3
    } perf_sel_e;

    function automatic logic [5:0] stall_encode(input logic rq_if, input logic rq_id,
                                                input logic rq_ex, input logic rq_mem);
        if (rq_mem) return StallMem;
        if (rq_ex)  return StallEx;
        if (rq_id)  return StallId;
        if (rq_if)  return StallIf;
        return StallNone;
    endfunction

endpackage

// File: rtl/pipe_stall_perf.sv
// Per-stage stall-cycle counter bank with a registered read mux.
module pipe_stall_perf
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  win_i,
    input  logic [1:0]  sel_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q [4];
    logic [31:0] rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
            rd_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (win_i[k] && (cnt_q[k] != 32'hFFFF_FFFF)) begin
                    cnt_q[k] <= cnt_q[k] + 32'd1;
                end
            end
            rd_q <= cnt_q[sel_i];
        end
    end

    assign cnt_o = rd_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 6-stage pipeline with stall watchdog.
// Optional per-stage stall counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        excp_valid_i,
    input  logic [31:0] excp_handler_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        new_pc_valid_o,
    output logic        stall_timeout_o,
    input  logic [1:0]  perf_sel_i,
    output logic [31:0] perf_cnt_o
);

    localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q;
    logic             flush_q;
    logic             valid_q;
    logic [31:0]      new_pc_q;
    logic [31:0]      hdl_q;
    logic [FcW-1:0]   fcnt_q;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             timeout_q, timeout_d;
    logic [5:0]       stall_pat;

    assign stall_pat = stall_encode(stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
    // flush_q is high exactly while in StFlush, so it doubles as the stall mask.
    assign stall_o   = (rst || flush_q) ? StallNone : stall_pat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            flush_q  <= 1'b0;
            valid_q  <= 1'b0;
            new_pc_q <= '0;
            hdl_q    <= '0;
            fcnt_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StRun: begin
                    if (excp_valid_i) begin
                        hdl_q <= excp_handler_i;
                        if (stallreq_mem_i) begin
                            state_q <= StWaitMem;
                        end else begin
                            state_q  <= StFlush;
                            flush_q  <= 1'b1;
                            valid_q  <= 1'b1;
                            new_pc_q <= excp_handler_i;
                            fcnt_q   <= FcW'(FLUSH_CYCLES - 1);
                        end
                    end
                end
                StWaitMem: begin
                    if (!stallreq_mem_i) begin
                        state_q  <= StFlush;
                        flush_q  <= 1'b1;
                        valid_q  <= 1'b1;
                        new_pc_q <= hdl_q;
                        fcnt_q   <= FcW'(FLUSH_CYCLES - 1);
                    end
                end
                StFlush: begin
                    if (fcnt_q == '0) begin
                        state_q <= StRun;
                        flush_q <= 1'b0;
                    end else begin
                        fcnt_q <= fcnt_q - FcW'(1);
                    end
                end
                default: begin
                    state_q <= StRun;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wd_d = wd_q;
        if (stall_o == StallNone) begin
            wd_d = '0;
        end else if (wd_q != TimeoutVal) begin
            wd_d = wd_q + CNT_W'(1);
        end
        timeout_d = timeout_q | (wd_d == TimeoutVal);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign flush_o         = flush_q;
    assign new_pc_o        = new_pc_q;
    assign new_pc_valid_o  = valid_q;
    assign stall_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [3:0] win;

    always_comb begin
        win          = '0;
        win[PerfIf]  = (stall_o == StallIf);
        win[PerfId]  = (stall_o == StallId);
        win[PerfEx]  = (stall_o == StallEx);
        win[PerfMem] = (stall_o == StallMem);
    end

    pipe_stall_perf u_perf (
        .clk   (clk),
        .rst   (rst),
        .win_i (win),
        .sel_i (perf_sel_i),
        .cnt_o (perf_cnt_o)
    );
`else
    logic unused_perf_sel;
    assign unused_perf_sel = ^perf_sel_i;
    assign perf_cnt_o      = '0;
`endif

endmodule
